majority_bist: RTL and testbench
================================

MAJORITY_BIST -- requirements
Module: majority_bist

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning the clock cycles each stimulus vector is held before the DUT response is sampled; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to run one exhaustive test pass, sampled only in IDLE.
REQ-005 The block SHALL have port dut_y, input, 1 bit, the response of the external 3-input majority DUT.
REQ-006 The block SHALL have ports dut_a, dut_b and dut_c, outputs, 1 bit each, the stimulus driven to the DUT inputs A, B and C.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a test pass is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a pass.
REQ-009 The block SHALL have port pass, output, 1 bit, meaning the last completed pass had zero mismatches.
REQ-010 The block SHALL have port err_count, output, 4 bits, the number of mismatching vectors in the current or last pass (range 0..8).
REQ-011 The block SHALL have port fail_vec, output, 8 bits, where bit i is set if vector i mismatched.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SETTLE, CHECK and DONE, plus a 3-bit vector index idx and a 4-bit settle counter cnt.
REQ-013 The stimulus SHALL be dut_a=idx[2], dut_b=idx[1], dut_c=idx[0]; vectors SHALL be applied in ascending order 000 through 111.
REQ-014 The expected response SHALL be maj(idx) = (a&b)|(a&c)|(b&c); vectors 3, 5, 6 and 7 expect 1, and all others expect 0.
REQ-015 In IDLE with start=1, the next edge SHALL go to SETTLE with idx=0, cnt=0, err_count=0, fail_vec=0, pass=0 and busy=1.
REQ-016 In SETTLE, each edge SHALL increment cnt; the edge at which cnt==SETTLE_CYCLES-1 SHALL go to CHECK.
REQ-017 In CHECK, the edge SHALL sample dut_y; on a mismatch it SHALL set fail_vec[idx] and increment err_count.
REQ-018 From CHECK with idx<7, the same edge SHALL increment idx, clear cnt and return to SETTLE; with idx==7 it SHALL go to DONE.
REQ-019 The stimulus SHALL remain stable through SETTLE and CHECK for each vector, for SETTLE_CYCLES+1 cycles per vector.
REQ-020 A pass SHALL take 8*(SETTLE_CYCLES+1) cycles from the start edge to DONE entry (24 cycles at the default).
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 0 and pass SHALL be (err_count==0); the next edge SHALL go to IDLE.
REQ-022 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-023 start SHALL be ignored in SETTLE, CHECK and DONE; no restart and no counter change SHALL result.
REQ-024 dut_a, dut_b and dut_c SHALL be 0 in IDLE and DONE.
REQ-025 err_count SHALL NOT wrap, since its maximum is 8 and it is 4 bits wide.

Reset
REQ-026 When rst_n=0, the block SHALL immediately (without a clock edge) set state=IDLE, idx=0, cnt=0, dut_a/b/c=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-027 Reset asserted mid-pass SHALL abort the pass with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-028 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-029 Correct majority DUT, default parameter, start pulse -> done at cycle 24, pass=1, err_count=0, fail_vec=8'h00.
REQ-030 dut_y stuck at 0 -> fail_vec=8'hE8, err_count=4, pass=0.
REQ-031 DUT wired as Y=A -> fail_vec=8'h18 (vectors 3 and 4), err_count=2, pass=0.
REQ-032 start pulsed at cycle 5 and cycle 12 of a pass -> no restart, done still at cycle 24, and results equal to the single-start run.
REQ-033 rst_n low at cycle 10 of a failing pass -> all outputs 0 asynchronously, no done; a fresh start with a good DUT -> pass=1.
REQ-034 SETTLE_CYCLES=1, back-to-back starts one cycle after done -> each pass is 16 cycles, and the second pass clears the first pass's fail_vec and err_count at its start edge.

Source files
------------

// File: rtl/majority_bist.sv
// Built-in self test for an external 3-input majority gate.
// Walks all eight input vectors in ascending order, holds each one for
// SETTLE_CYCLES cycles, then compares the gate's response against the
// majority function and records per-vector mismatches.
module majority_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last settle count before the response is considered stable.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_reg;
    logic [2:0] idx_reg;
    logic [3:0] cnt_reg;

    logic       exp_y;
    logic       mismatch;
    logic [3:0] err_next;
    logic [2:0] idx_inc;

    // Golden majority response for the vector under test and the
    // error count including the current comparison (max 8, never wraps).
    always_comb begin
        exp_y    = (idx_reg[2] & idx_reg[1]) | (idx_reg[2] & idx_reg[0]) |
                   (idx_reg[1] & idx_reg[0]);
        mismatch = (dut_y != exp_y);
        err_next = err_count + {3'b000, mismatch};
        idx_inc  = idx_reg + 3'd1;
    end

    // Test sequencer: all control state and outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= 4'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            dut_c     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= SETTLE;
                        idx_reg   <= 3'd0;
                        cnt_reg   <= 4'd0;
                        {dut_a, dut_b, dut_c} <= 3'b000;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= 4'd0;
                        fail_vec  <= 8'd0;
                    end
                end
                SETTLE: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == SETTLE_LAST) begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    fail_vec  <= fail_vec | (8'(mismatch) << idx_reg);
                    if (idx_reg != 3'd7) begin
                        state_reg <= SETTLE;
                        idx_reg   <= idx_inc;
                        cnt_reg   <= 4'd0;
                        {dut_a, dut_b, dut_c} <= idx_inc;
                    end else begin
                        // Last vector: pass verdict includes this comparison.
                        state_reg <= DONE;
                        {dut_a, dut_b, dut_c} <= 3'b000;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_next == 4'd0);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_majority_bist.sv
// Scoreboard bench for majority_bist: two instances (default settle time and
// SETTLE_CYCLES=1), each driving a behavioural gate with selectable faults.
module tb_majority_bist;

    typedef struct {
        logic       p;
        logic [3:0] e;
        logic [7:0] fv;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start0, start1;
    logic y0, y1;
    logic a0, b0, c0, a1, b1, c1;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [3:0] err0, err1;
    logic [7:0] fv0, fv1;
    int mode0, mode1;

    exp_t q0[$];
    exp_t q1[$];
    int cyc;
    int total_cnt;
    int pass_cnt;
    int start_cyc0, start_cyc1;
    logic busy0_prev, busy1_prev;

    majority_bist u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0),
        .dut_a(a0), .dut_b(b0), .dut_c(c0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0)
    );

    majority_bist #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y1),
        .dut_a(a1), .dut_b(b1), .dut_c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    // Behavioural gate under test: 0 good majority, 1 stuck-0, 2 Y=A, 3 stuck-1.
    function automatic logic gate(int mode, logic a, logic b, logic c);
        case (mode)
            0:       return (a & b) | (a & c) | (b & c);
            1:       return 1'b0;
            2:       return a;
            default: return 1'b1;
        endcase
    endfunction

    always_comb y0 = gate(mode0, a0, b0, c0);
    always_comb y1 = gate(mode1, a1, b1, c1);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total_cnt++;
        if (act !== req)
            $display("FAIL %s: got %0h required %0h", name, act, req);
        else
            pass_cnt++;
    endtask

    // Monitor for the default instance: pops an expectation on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (busy0 === 1'b1 && busy0_prev !== 1'b1) start_cyc0 = cyc;
        busy0_prev = busy0;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("unexpected_done0", 32'(done0), 32'd0);
            end else begin
                e = q0.pop_front();
                $display("u0 pass end: pass=%0d err=%0d fv=%02h cycles=%0d",
                         pass0, err0, fv0, cyc - start_cyc0);
                check("pass0", 32'(pass0), 32'(e.p));
                check("err0", 32'(err0), 32'(e.e));
                check("fv0", 32'(fv0), 32'(e.fv));
                check("cycles0", 32'(cyc - start_cyc0), 32'(e.cyc));
            end
        end
    end

    // Monitor for the SETTLE_CYCLES=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (busy1 === 1'b1 && busy1_prev !== 1'b1) start_cyc1 = cyc;
        busy1_prev = busy1;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 32'(done1), 32'd0);
            end else begin
                e = q1.pop_front();
                $display("u1 pass end: pass=%0d err=%0d fv=%02h cycles=%0d",
                         pass1, err1, fv1, cyc - start_cyc1);
                check("pass1", 32'(pass1), 32'(e.p));
                check("err1", 32'(err1), 32'(e.e));
                check("fv1", 32'(fv1), 32'(e.fv));
                check("cycles1", 32'(cyc - start_cyc1), 32'(e.cyc));
            end
        end
    end

    task automatic push0(logic p, logic [3:0] e, logic [7:0] fv);
        exp_t x;
        x.p = p; x.e = e; x.fv = fv; x.cyc = 24;
        q0.push_back(x);
    endtask

    task automatic push1(logic p, logic [3:0] e, logic [7:0] fv);
        exp_t x;
        x.p = p; x.e = e; x.fv = fv; x.cyc = 16;
        q1.push_back(x);
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_q0(int budget);
        int n;
        n = 0;
        while (q0.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0) begin
            check("timeout_q0", 32'(q0.size()), 32'd0);
            q0.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_q1(int budget);
        int n;
        n = 0;
        while (q1.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0) begin
            check("timeout_q1", 32'(q1.size()), 32'd0);
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        cyc = 0; total_cnt = 0; pass_cnt = 0;
        start_cyc0 = 0; start_cyc1 = 0;
        busy0_prev = 1'b0; busy1_prev = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        mode0 = 0; mode1 = 0;
        rst_n = 1'b1;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_fv", 32'(fv0), 32'd0);
        check("rst_abc", 32'({a0, b0, c0}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Good gate, start accepted on first edge after reset release.
        mode0 = 0;
        push0(1'b1, 4'd0, 8'h00);
        pulse_start0();
        wait_q0(40);

        // Stuck-at-0 output.
        mode0 = 1;
        push0(1'b0, 4'd4, 8'hE8);
        pulse_start0();
        wait_q0(40);

        // Gate wired as Y=A; results must then hold while idle.
        mode0 = 2;
        push0(1'b0, 4'd2, 8'h18);
        pulse_start0();
        wait_q0(40);
        repeat (3) @(negedge clk);
        check("hold_pass", 32'(pass0), 32'd0);
        check("hold_err", 32'(err0), 32'd2);
        check("hold_fv", 32'(fv0), 32'h18);
        check("idle_abc", 32'({a0, b0, c0}), 32'd0);

        // Extra start pulses at cycles 5 and 12 are ignored.
        push0(1'b0, 4'd2, 8'h18);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_q0(40);

        // Reset at cycle 10 of a failing (stuck-at-1) pass.
        mode0 = 3;
        pulse_start0();
        repeat (10) @(negedge clk);
        check("mid_err", 32'(err0), 32'd3);
        check("mid_fv", 32'(fv0), 32'h07);
        check("mid_abc", 32'({a0, b0, c0}), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_err", 32'(err0), 32'd0);
        check("abort_fv", 32'(fv0), 32'd0);
        check("abort_abc", 32'({a0, b0, c0}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy0), 32'd0);

        // Fresh start with a good gate after the abort.
        mode0 = 0;
        push0(1'b1, 4'd0, 8'h00);
        pulse_start0();
        wait_q0(40);

        // SETTLE_CYCLES=1: failing pass, then a good pass started right after done.
        mode1 = 1;
        push1(1'b0, 4'd4, 8'hE8);
        push1(1'b1, 4'd0, 8'h00);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done1 !== 1'b1) check("timeout_done1", 32'(done1), 32'd1);
        mode1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("b2b_busy", 32'(busy1), 32'd1);
        check("b2b_err_clr", 32'(err1), 32'd0);
        check("b2b_fv_clr", 32'(fv1), 32'd0);
        wait_q1(40);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
